// File: rtl/uart_byte_tx_pkg.sv
// Shared UART definitions: FSM state encoding and the default baud divisor.
// A future receiver is expected to import the same package.
package uart_byte_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_DONE  = 3'd4
    } uart_state_e;

    // 50 MHz system clock divided down to 115200 baud.
    localparam int UART_CLKS_PER_BIT_115200 = 434;

endpackage

// File: rtl/uart_byte_tx_baud_tick_gen.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// A held clear keeps the count at zero so the next bit starts fresh.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + CW'(1);
        if (clear || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8-N-1 UART transmitter: one frame per rising edge of sendready, one-cycle
// ready pulse once the stop bit has fully left the pin.
module uart_byte_tx
    import uart_byte_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_115200
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  datain,
    input  logic        sendready,
    output logic        tx,
    output logic        ready,
    output logic        busy,
    output uart_state_e dbg_state
);

    // Handshake: a rising edge of sendready seen in IDLE is accepted and
    // datain is captured on that edge; edges seen in any other state are
    // dropped. ready pulses for one cycle when the frame is complete.

    uart_state_e state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic        sr_q, sr_d;
    logic        tx_q, tx_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        req;
    logic        tick;
    logic        baud_clear;

    assign req        = sendready & ~sr_q;
    assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

    baud_tick_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock (clock),
        .reset (reset),
        .clear (baud_clear),
        .tick  (tick)
    );

    // Outputs are computed from the next state so they change on the same
    // edge as the state, keeping tx aligned with the bit boundaries.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        sr_d      = sendready;
        tx_d      = tx_q;
        ready_d   = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            ST_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (req) begin
                    shift_d   = datain;
                    bit_idx_d = 3'd0;
                    state_d   = ST_START;
                    tx_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d = shift_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    state_d = ST_DONE;
                    ready_d = 1'b1;
                    tx_d    = 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= 8'h00;
            bit_idx_q <= 3'd0;
            sr_q      <= 1'b0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            sr_q      <= sr_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign tx        = tx_q;
    assign ready     = ready_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx at 4 clocks per bit (40-cycle frame).
module tb_uart_byte_tx;
    import uart_byte_tx_pkg::*;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        sendready;
    logic [7:0]  datain;
    logic        tx;
    logic        ready;
    logic        busy;
    uart_state_e dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    uart_byte_tx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .datain    (datain),
        .sendready (sendready),
        .tx        (tx),
        .ready     (ready),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Raise sendready and check every cycle of the frame plus the cycle after.
    // mode 1: datain changes to 0xFF right after acceptance
    // mode 2: sendready pulses low/high mid-frame (must be ignored)
    // mode 3: sendready drops during the ready cycle for a back-to-back frame
    task automatic send_and_check(input logic [7:0] b, input int mode);
        logic exp_tx;
        int   bitpos;
        datain    = b;
        sendready = 1'b1;
        for (int k = 1; k <= 42; k++) begin
            step();
            if (k <= 40) begin
                bitpos = (k - 1) / CPB;
                if (bitpos == 0)      exp_tx = 1'b0;
                else if (bitpos == 9) exp_tx = 1'b1;
                else                  exp_tx = b[bitpos-1];
            end else begin
                exp_tx = 1'b1;
            end
            check($sformatf("tx byte=%0h k=%0d", b, k), 32'(tx), 32'(exp_tx));
            check($sformatf("busy byte=%0h k=%0d", b, k), 32'(busy), 32'(k <= 41));
            check($sformatf("ready byte=%0h k=%0d", b, k), 32'(ready), 32'(k == 41));
            if (mode == 1 && k == 1)  datain = 8'hFF;
            if (mode == 2 && k == 9)  sendready = 1'b0;
            if (mode == 2 && k == 10) sendready = 1'b1;
            if (mode == 3 && k == 41) sendready = 1'b0;
        end
    endtask

    initial begin
        reset     = 1'b1;
        sendready = 1'b0;
        datain    = 8'h00;

        for (int i = 0; i < 3; i++) begin
            step();
            check("rst tx", 32'(tx), 32'd1);
            check("rst ready", 32'(ready), 32'd0);
            check("rst busy", 32'(busy), 32'd0);
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle tx", 32'(tx), 32'd1);
            check("idle ready", 32'(ready), 32'd0);
            check("idle busy", 32'(busy), 32'd0);
            check("idle state", 32'(dbg_state), 32'(ST_IDLE));
        end

        send_and_check(8'h55, 0);
        sendready = 1'b0;
        step();

        send_and_check(8'hA3, 1);
        sendready = 1'b0;
        step();

        // Level held for 200 cycles in total: one frame only.
        send_and_check(8'h3C, 0);
        for (int i = 0; i < 158; i++) begin
            step();
            check("held ready", 32'(ready), 32'd0);
            check("held busy", 32'(busy), 32'd0);
            check("held tx", 32'(tx), 32'd1);
        end
        sendready = 1'b0;
        step();

        // Back-to-back: second rising edge lands in the IDLE cycle after DONE.
        send_and_check(8'hC1, 3);
        send_and_check(8'h0F, 0);
        sendready = 1'b0;
        step();

        send_and_check(8'h96, 2);
        sendready = 1'b0;
        step();

        // Reset in the middle of a data bit, sendready left high.
        datain    = 8'h81;
        sendready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        reset  = 1'b1;
        datain = 8'h5A;
        step();
        check("midrst tx", 32'(tx), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst ready", 32'(ready), 32'd0);
        check("midrst state", 32'(dbg_state), 32'(ST_IDLE));
        reset = 1'b0;
        send_and_check(8'h5A, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
